// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte receiver and echo transmitter.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // Integer-truncated clocks per bit for a given clock frequency and baud rate
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 serial byte transmitter: start(0), 8 data bits LSB-first, stop(1).
// Latency: uart_tx goes low the cycle after tx_start is accepted in T_IDLE.
// Backpressure: tx_start is ignored while tx_busy is high; no queueing.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_q, tx_nxt;

  // State, bit timer, shifter and the registered line driver
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= T_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      tx_q  <= tx_nxt;
    end
  end

  // Next state: each bit is held for CLKS_PER_BIT cycles; line value is computed one cycle ahead
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    shift_nxt = shift;
    tx_nxt    = tx_q;
    case (state)
      T_IDLE: begin
        cnt_nxt = '0;
        tx_nxt  = 1'b1;
        if (tx_start) begin
          state_nxt = T_START;
          shift_nxt = tx_data;
          tx_nxt    = 1'b0;
        end
      end
      T_START: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = T_DATA;
          tx_nxt    = shift[0];
        end
      end
      T_DATA: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = idx + 3'd1;
          shift_nxt = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
            state_nxt = T_STOP;
            tx_nxt    = 1'b1;
          end else begin
            tx_nxt = shift[1];
          end
        end
      end
      T_STOP: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = T_IDLE;
        end
      end
      default: begin
        state_nxt = T_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  assign tx_busy = (state != T_IDLE);
  assign uart_tx = tx_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver holding the last good byte, with valid/framing strobes and optional echo.
// Latency: rx_valid rises 2 + HALF-1 + 9*CLKS_PER_BIT + 1 cycles after the start-bit edge at the pin.
// Backpressure: none; strobes are one-cycle pulses, echo drops bytes that arrive while busy.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 27000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter bit ECHO         = 1'b1
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] last_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync_q, rx_s, rx_s_d;
  rx_state_t     rx_state, rx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    byte_nxt;
  logic          vld_nxt, ferr_nxt;

  // Two-flop synchronizer, plus one delay stage so IDLE only starts on a real high-to-low edge
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= uart_rx;
      rx_s   <= sync_q;
      rx_s_d <= rx_s;
    end
  end

  // Receiver state, bit timer, shifter and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      last_byte <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shift     <= shift_nxt;
      last_byte <= byte_nxt;
      rx_valid  <= vld_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // Next state: the edge-detect cycle counts as cycle 0, so START leaves the counter at 1
  always_comb begin
    rx_nxt    = rx_state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    shift_nxt = shift;
    byte_nxt  = last_byte;
    vld_nxt   = 1'b0;
    ferr_nxt  = 1'b0;
    case (rx_state)
      IDLE: begin
        cnt_nxt = '0;
        if (rx_s_d && !rx_s) begin
          rx_nxt  = START;
          cnt_nxt = CW'(1);
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          rx_nxt  = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = idx + 3'd1;
          shift_nxt = {rx_s, shift[7:1]};
          if (idx == 3'd7) rx_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            byte_nxt = shift;
            vld_nxt  = 1'b1;
            rx_nxt   = IDLE;
          end else begin
            ferr_nxt = 1'b1;
            rx_nxt   = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) rx_nxt = IDLE;
      end
      default: begin
        cnt_nxt = '0;
        rx_nxt  = IDLE;
      end
    endcase
  end

  // Optional echo of every good byte; bytes arriving mid-echo are not retransmitted
  generate
    if (ECHO) begin : g_echo
      logic echo_busy;
      uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .tx_start(rx_valid & ~echo_busy),
        .tx_data (last_byte),
        .tx_busy (echo_busy),
        .uart_tx (uart_tx)
      );
    end else begin : g_no_echo
      assign uart_tx = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx at CLKS_PER_BIT = 8: vector table, corner-case sequences, random frames.
// Expected strobe times come from frame arithmetic: start-bit fall + 78 cycles.
// Line values are driven one time unit after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int CPB = 8;
  localparam int LAT = 2 + (CPB / 2 - 1) + 9 * CPB + 1;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] last_byte;
  logic       rx_valid;
  logic       frame_err;

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .ECHO(1'b1)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .last_byte(last_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int         checks   = 0;
  int         failures = 0;
  int         vq[$];
  logic [7:0] bq[$];
  int         fq[$];
  int         both_cnt = 0;
  bit         txlog[int];

  // Record strobe times, received bytes and the tx line every cycle
  always @(negedge sys_clk) begin
    txlog[cyc] = uart_tx;
    if (rst_n) begin
      if (rx_valid) begin
        vq.push_back(cyc);
        bq.push_back(last_byte);
      end
      if (frame_err) fq.push_back(cyc);
      if (rx_valid && frame_err) both_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic clear_q();
    vq.delete();
    bq.delete();
    fq.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, output int t_fall);
    uart_rx = 1'b0;
    t_fall  = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = stop_ok;
    tick(CPB);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop_ok;
    int         n_vld;
    int         n_ferr;
    logic [7:0] exp_last;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vt[6];
    int         t, t1, t2, v0, v1;
    logic [7:0] eb_byte;
    int         evq[$];
    logic [7:0] ebq[$];
    int         efq[$];
    logic [7:0] mlast;
    bit         ok, eb;

    vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vt[1] = '{8'h55, 1'b0, 0, 1, 8'hA5};
    vt[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vt[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vt[4] = '{8'h6E, 1'b0, 0, 1, 8'hFF};
    vt[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

    // Reset state
    tick(3);
    chk("reset last_byte", last_byte, 8'h00);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset uart_tx", uart_tx, 1);
    rst_n = 1'b1;
    tick(4);

    // Vector table: single frames, good and bad stop bits
    for (int k = 0; k < 6; k++) begin
      clear_q();
      send_frame(vt[k].d, vt[k].stop_ok, t);
      uart_rx = 1'b1;
      tick(2 * CPB);
      chk($sformatf("vec%0d n_vld", k), vq.size(), vt[k].n_vld);
      chk($sformatf("vec%0d n_ferr", k), fq.size(), vt[k].n_ferr);
      chk($sformatf("vec%0d last_byte", k), last_byte, vt[k].exp_last);
      if (vq.size() > 0) chk($sformatf("vec%0d vld latency", k), vq[0] - t, LAT);
      if (fq.size() > 0) chk($sformatf("vec%0d ferr latency", k), fq[0] - t, LAT);
    end

    // Back-to-back frames with a single stop bit
    tick(100);
    clear_q();
    send_frame(8'h3C, 1'b1, t1);
    send_frame(8'hC3, 1'b1, t2);
    uart_rx = 1'b1;
    tick(2 * CPB);
    chk("b2b count", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("b2b first latency", vq[0] - t1, LAT);
      chk("b2b spacing", vq[1] - vq[0], 80);
      chk("b2b byte0", bq[0], 8'h3C);
      chk("b2b byte1", bq[1], 8'hC3);
    end
    chk("b2b last_byte", last_byte, 8'hC3);

    // Bad stop followed by a long break, then recovery
    clear_q();
    send_frame(8'h55, 1'b0, t);
    uart_rx = 1'b0;
    tick(40 * CPB);
    chk("break ferr count", fq.size(), 1);
    chk("break no vld", vq.size(), 0);
    chk("break last_byte kept", last_byte, 8'hC3);
    uart_rx = 1'b1;
    tick(2 * CPB);
    clear_q();
    send_frame(8'h81, 1'b1, t);
    uart_rx = 1'b1;
    tick(2 * CPB);
    chk("after break vld count", vq.size(), 1);
    chk("after break last_byte", last_byte, 8'h81);

    // Two-cycle glitch, then a start bit arriving as soon as the receiver is idle again
    tick(100);
    clear_q();
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(3);
    send_frame(8'h7E, 1'b1, t);
    uart_rx = 1'b1;
    tick(2 * CPB);
    chk("glitch no ferr", fq.size(), 0);
    chk("glitch only real frame", vq.size(), 1);
    if (vq.size() == 1) chk("post-glitch latency", vq[0] - t, LAT);
    chk("post-glitch last_byte", last_byte, 8'h7E);

    // Echo waveform, and a second byte arriving mid-echo is not retransmitted
    tick(100);
    clear_q();
    eb_byte = 8'h5A;
    send_frame(8'h5A, 1'b1, t1);
    send_frame(8'h99, 1'b1, t2);
    uart_rx = 1'b1;
    tick(200);
    chk("echo vld count", vq.size(), 2);
    chk("echo last_byte", last_byte, 8'h99);
    if (vq.size() == 2) begin
      v0 = vq[0];
      v1 = vq[1];
      chk("echo idle at rx_valid", txlog[v0], 1);
      for (int b = 0; b < 10; b++) begin
        eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb_byte[b-1];
        ok = 1'b1;
        for (int j = 0; j < CPB; j++)
          if (txlog[v0 + 1 + b * CPB + j] != eb) ok = 1'b0;
        chk($sformatf("echo bit%0d", b), {31'd0, ok}, 1);
      end
      ok = 1'b1;
      for (int j = 1; j <= 80; j++)
        if (txlog[v1 + j] != 1'b1) ok = 1'b0;
      chk("second byte not echoed", {31'd0, ok}, 1);
    end

    // Reset in the middle of data bit 3 of 8'hFF
    tick(50);
    clear_q();
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(3 * CPB + 4);
    rst_n = 1'b0;
    #1;
    chk("midreset last_byte", last_byte, 8'h00);
    chk("midreset rx_valid", rx_valid, 0);
    chk("midreset frame_err", frame_err, 0);
    chk("midreset uart_tx", uart_tx, 1);
    tick(3);
    rst_n = 1'b1;
    tick(5 * CPB + 20);
    chk("midreset no vld", vq.size(), 0);
    chk("midreset no ferr", fq.size(), 0);
    send_frame(8'h12, 1'b1, t);
    uart_rx = 1'b1;
    tick(2 * CPB);
    chk("after reset vld count", vq.size(), 1);
    if (vq.size() == 1) chk("after reset latency", vq[0] - t, LAT);
    chk("after reset last_byte", last_byte, 8'h12);

    // Random frames against a frame-level model
    tick(100);
    clear_q();
    mlast = last_byte;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit         good;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      send_frame(d, good, t);
      if (good) begin
        evq.push_back(t + LAT);
        ebq.push_back(d);
        mlast = d;
      end else begin
        efq.push_back(t + LAT);
      end
      gap = good ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
      uart_rx = 1'b1;
      tick(gap);
    end
    uart_rx = 1'b1;
    tick(2 * CPB);
    chk("rand vld count", vq.size(), evq.size());
    chk("rand ferr count", fq.size(), efq.size());
    for (int i = 0; i < vq.size() && i < evq.size(); i++) begin
      chk($sformatf("rand vld%0d time", i), vq[i], evq[i]);
      chk($sformatf("rand vld%0d byte", i), bq[i], ebq[i]);
    end
    for (int i = 0; i < fq.size() && i < efq.size(); i++)
      chk($sformatf("rand ferr%0d time", i), fq[i], efq[i]);
    chk("rand last_byte", last_byte, mlast);
    chk("strobes never together", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
